// File: rtl/riscv_pkg.sv
// Shared types and constants for the EX pipeline stages.
package riscv_pkg;

  localparam int XLEN = 32;

  // ALU function codes carried in alu_op[2:0]
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_e;

  // Skid buffer occupancy, encoded as {skid_valid, out_valid}; 2'b10 is illegal
  typedef enum logic [1:0] {
    SB_EMPTY = 2'b00,
    SB_ONE   = 2'b01,
    SB_FULL  = 2'b11
  } skid_state_e;

  // Everything EX3 hands to EX4 besides the valid bit
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      rd_addr;
    logic            zero;
    logic            neg;
  } ex3_payload_t;

endpackage

// File: rtl/riscv_skid_buf.sv
// Two-slot skid buffer with a registered ready, flush and a saturating
// stall counter. Reusable at any valid/ready pipeline boundary.
//
// Handshake: an input beat transfers on a clock edge where
// in_valid && in_ready; an output beat transfers on a clock edge where
// out_valid && out_ready. The upstream must hold in_data stable while
// in_valid && !in_ready. in_ready is a pure flop output.
module riscv_skid_buf
  import riscv_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output skid_state_e      state
);

  logic [W-1:0] skid_data;
  logic         accept;
  logic         drain;

  assign out_valid = state[0];
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Occupancy FSM; ready for next cycle is the inverse of next skid_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SB_EMPTY;
      in_ready <= 1'b1;
    end else if (flush) begin
      state    <= SB_EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (state)
        SB_EMPTY: begin
          if (accept) state <= SB_ONE;
        end
        SB_ONE: begin
          if (accept && !drain) begin
            state    <= SB_FULL;
            in_ready <= 1'b0;
          end else if (!accept && drain) begin
            state <= SB_EMPTY;
          end
        end
        SB_FULL: begin
          // in_ready is low here, so only a drain can happen
          if (drain) begin
            state    <= SB_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= SB_EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Payload slots; contents are meaningless while the matching valid is low
  always_ff @(posedge clk) begin
    if (state == SB_FULL) begin
      if (drain) out_data <= skid_data;
    end else if (accept) begin
      if (!out_valid || drain) out_data  <= in_data;
      else                     skid_data <= in_data;
    end
  end

  // Count back-pressured cycles, saturating; flush leaves it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_ex3_stage.sv
// EX3: second cycle of the ALU. Finishes shifts, derives zero/neg flags
// and presents a registered, back-pressurable result to EX4.
module riscv_ex3_stage
  import riscv_pkg::*;
#(
  // Must match riscv_pkg::XLEN, which sizes the payload struct
  parameter int XLEN        = riscv_pkg::XLEN,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        ex2_alu_in1,
  input  logic [XLEN-1:0]        ex2_alu_in2,
  input  logic [XLEN-1:0]        ex2_alu_partial,
  input  logic [3:0]             ex2_alu_op,
  input  logic [4:0]             ex2_rd_addr,
  input  logic                   ex2_valid,
  output logic                   ex3_ready,
  input  logic                   ex3_flush,
  input  logic                   ex4_ready,
  output logic [XLEN-1:0]        ex3_result,
  output logic [4:0]             ex3_rd_addr,
  output logic                   ex3_zero,
  output logic                   ex3_neg,
  output logic                   ex3_valid,
  output logic [STALL_CNT_W-1:0] ex3_stall_cnt
);

  localparam int PW = $bits(ex3_payload_t);

  alu_op_e      op;
  logic [4:0]   shamt;
  logic [XLEN-1:0] result;
  ex3_payload_t in_payload;
  ex3_payload_t out_payload;
  skid_state_e  dbg_skid_state;
  logic         unused_bits;

  assign op    = alu_op_e'(ex2_alu_op[2:0]);
  assign shamt = ex2_alu_in2[4:0];

  // Finish shifts; all other ops were completed by EX2
  always_comb begin
    result = ex2_alu_partial;
    case (op)
      ALU_SLL: result = ex2_alu_in1 << shamt;
      ALU_SRL: result = ex2_alu_in1 >> shamt;
      ALU_SRA: result = $signed(ex2_alu_in1) >>> shamt;
      default: result = ex2_alu_partial;
    endcase
  end

  // Flags come from the final result so EX4 never recomputes them
  always_comb begin
    in_payload.result  = result;
    in_payload.rd_addr = ex2_rd_addr;
    in_payload.zero    = (result == '0);
    in_payload.neg     = result[XLEN-1];
  end

  // imm-select and upper shift bits are informational at this stage
  assign unused_bits = ^{ex2_alu_op[3], ex2_alu_in2[XLEN-1:5], dbg_skid_state};

  riscv_skid_buf #(
    .W     (PW),
    .CNT_W (STALL_CNT_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (ex2_valid),
    .in_ready  (ex3_ready),
    .in_data   (in_payload),
    .flush     (ex3_flush),
    .out_ready (ex4_ready),
    .out_valid (ex3_valid),
    .out_data  (out_payload),
    .stall_cnt (ex3_stall_cnt),
    .state     (dbg_skid_state)
  );

  assign ex3_result  = out_payload.result;
  assign ex3_rd_addr = out_payload.rd_addr;
  assign ex3_zero    = out_payload.zero;
  assign ex3_neg     = out_payload.neg;

endmodule

// File: tb/tb_riscv_ex3_stage.sv
// Directed bench for riscv_ex3_stage with hand-computed expectations.
module tb_riscv_ex3_stage;

  localparam int XLEN = 32;
  localparam int CW   = 16;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] ex2_alu_in1;
  logic [XLEN-1:0] ex2_alu_in2;
  logic [XLEN-1:0] ex2_alu_partial;
  logic [3:0]      ex2_alu_op;
  logic [4:0]      ex2_rd_addr;
  logic            ex2_valid;
  logic            ex3_ready;
  logic            ex3_flush;
  logic            ex4_ready;
  logic [XLEN-1:0] ex3_result;
  logic [4:0]      ex3_rd_addr;
  logic            ex3_zero;
  logic            ex3_neg;
  logic            ex3_valid;
  logic [CW-1:0]   ex3_stall_cnt;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] got_q[$];
  logic [XLEN-1:0] exp_q[$];

  riscv_ex3_stage #(.XLEN(XLEN), .STALL_CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex2_alu_in1     (ex2_alu_in1),
    .ex2_alu_in2     (ex2_alu_in2),
    .ex2_alu_partial (ex2_alu_partial),
    .ex2_alu_op      (ex2_alu_op),
    .ex2_rd_addr     (ex2_rd_addr),
    .ex2_valid       (ex2_valid),
    .ex3_ready       (ex3_ready),
    .ex3_flush       (ex3_flush),
    .ex4_ready       (ex4_ready),
    .ex3_result      (ex3_result),
    .ex3_rd_addr     (ex3_rd_addr),
    .ex3_zero        (ex3_zero),
    .ex3_neg         (ex3_neg),
    .ex3_valid       (ex3_valid),
    .ex3_stall_cnt   (ex3_stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record every output transfer, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && ex3_valid && ex4_ready) got_q.push_back(ex3_result);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [XLEN-1:0] in1,
                       input logic [XLEN-1:0] in2, input logic [XLEN-1:0] part,
                       input logic [4:0] rd);
    ex2_valid       = v;
    ex2_alu_op      = op;
    ex2_alu_in1     = in1;
    ex2_alu_in2     = in2;
    ex2_alu_partial = part;
    ex2_rd_addr     = rd;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag);
    chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
  endtask

  initial begin
    rst       = 1'b1;
    ex3_flush = 1'b0;
    ex4_ready = 1'b1;
    drive(1'b0, 4'd0, '0, '0, '0, 5'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_valid", 64'(ex3_valid), 64'd0);
    chk("rst_ready", 64'(ex3_ready), 64'd1);
    chk("rst_cnt",   64'(ex3_stall_cnt), 64'd0);

    // SLL: shamt = 0x24[4:0] = 4
    drive(1'b1, 4'd5, 32'h0000_0001, 32'h0000_0024, 32'hDEAD_BEEF, 5'd3);
    tick();
    chk("sll_valid",  64'(ex3_valid), 64'd1);
    chk("sll_result", 64'(ex3_result), 64'h0000_0010);
    chk("sll_zero",   64'(ex3_zero), 64'd0);
    chk("sll_neg",    64'(ex3_neg), 64'd0);
    chk("sll_rd",     64'(ex3_rd_addr), 64'd3);

    // SRA by 31
    drive(1'b1, 4'd7, 32'h8000_0000, 32'd31, 32'h0, 5'd4);
    tick();
    chk("sra_result", 64'(ex3_result), 64'hFFFF_FFFF);
    chk("sra_neg",    64'(ex3_neg), 64'd1);

    // SRL by 31
    drive(1'b1, 4'd6, 32'h8000_0000, 32'd31, 32'h0, 5'd5);
    tick();
    chk("srl_result", 64'(ex3_result), 64'h0000_0001);
    chk("srl_neg",    64'(ex3_neg), 64'd0);

    // SUB passthrough of zero
    drive(1'b1, 4'd1, 32'h1234_5678, 32'h1234_5678, 32'h0, 5'd6);
    tick();
    chk("sub_result", 64'(ex3_result), 64'h0);
    chk("sub_zero",   64'(ex3_zero), 64'd1);

    // ADD passthrough, negative; imm-select bit set must not matter
    drive(1'b1, 4'd8, 32'h0, 32'hFFFF_FFFF, 32'h8000_0001, 5'd7);
    tick();
    chk("add_result", 64'(ex3_result), 64'h8000_0001);
    chk("add_neg",    64'(ex3_neg), 64'd1);
    chk("add_zero",   64'(ex3_zero), 64'd0);
    chk("add_rd",     64'(ex3_rd_addr), 64'd7);

    drive(1'b0, 4'd0, '0, '0, '0, 5'd0);
    tick();
    chk("idle_valid", 64'(ex3_valid), 64'd0);
    chk("idle_cnt",   64'(ex3_stall_cnt), 64'd0);

    // back-pressure: A, B, C with EX4 stalled
    got_q.delete();
    exp_q = '{32'hA, 32'hB, 32'hC};
    ex4_ready = 1'b0;
    drive(1'b1, 4'd0, '0, '0, 32'hA, 5'd1);
    tick();
    chk("bp_a_valid",  64'(ex3_valid), 64'd1);
    chk("bp_a_result", 64'(ex3_result), 64'hA);
    chk("bp_a_ready",  64'(ex3_ready), 64'd1);
    drive(1'b1, 4'd0, '0, '0, 32'hB, 5'd2);
    tick();
    chk("bp_full_ready", 64'(ex3_ready), 64'd0);
    chk("bp_full_out",   64'(ex3_result), 64'hA);
    chk("bp_cnt1",       64'(ex3_stall_cnt), 64'd1);
    drive(1'b1, 4'd0, '0, '0, 32'hC, 5'd3);
    tick();
    tick();
    chk("bp_hold_ready", 64'(ex3_ready), 64'd0);
    chk("bp_hold_out",   64'(ex3_result), 64'hA);
    chk("bp_cnt3",       64'(ex3_stall_cnt), 64'd3);
    ex4_ready = 1'b1;
    tick();
    chk("bp_b_out",   64'(ex3_result), 64'hB);
    chk("bp_b_rd",    64'(ex3_rd_addr), 64'd2);
    chk("bp_b_ready", 64'(ex3_ready), 64'd1);
    tick();
    drive(1'b0, 4'd0, '0, '0, '0, 5'd0);
    chk("bp_c_out", 64'(ex3_result), 64'hC);
    chk("bp_c_rd",  64'(ex3_rd_addr), 64'd3);
    tick();
    chk("bp_empty", 64'(ex3_valid), 64'd0);
    chk("bp_cnt",   64'(ex3_stall_cnt), 64'd3);
    chk_q("bp_order");

    // flush while FULL, with a new op offered; D drains on the flush edge
    got_q.delete();
    exp_q = '{32'hD};
    ex4_ready = 1'b0;
    drive(1'b1, 4'd0, '0, '0, 32'hD, 5'd8);
    tick();
    drive(1'b1, 4'd0, '0, '0, 32'hE, 5'd9);
    tick();
    chk("fl_full_ready", 64'(ex3_ready), 64'd0);
    chk("fl_cnt_before", 64'(ex3_stall_cnt), 64'd4);
    drive(1'b1, 4'd0, '0, '0, 32'hF, 5'd10);
    ex3_flush = 1'b1;
    ex4_ready = 1'b1;
    tick();
    ex3_flush = 1'b0;
    drive(1'b0, 4'd0, '0, '0, '0, 5'd0);
    chk("fl_valid", 64'(ex3_valid), 64'd0);
    chk("fl_ready", 64'(ex3_ready), 64'd1);
    chk("fl_cnt",   64'(ex3_stall_cnt), 64'd4);
    tick();
    tick();
    chk("fl_still_empty", 64'(ex3_valid), 64'd0);
    chk_q("fl_out");

    // saturate the stall counter
    ex4_ready = 1'b0;
    drive(1'b1, 4'd0, '0, '0, 32'h5A5A_0000, 5'd11);
    tick();
    drive(1'b0, 4'd0, '0, '0, '0, 5'd0);
    repeat (70000) tick();
    chk("sat_valid", 64'(ex3_valid), 64'd1);
    chk("sat_cnt",   64'(ex3_stall_cnt), 64'hFFFF);
    chk("sat_out",   64'(ex3_result), 64'h5A5A_0000);

    // asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(ex3_valid), 64'd0);
    chk("arst_ready", 64'(ex3_ready), 64'd1);
    chk("arst_cnt",   64'(ex3_stall_cnt), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 64'(ex3_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
